// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the request/response handshake between the memory stage and the
//   load/store unit, and the ReadEnable/WriteEnable bus between the load/store
//   unit and the word-addressed data memory.
//
//   slave  : view of the load/store unit itself
//            in : ReqValid, ReqWrite, ReqFunct3, ReqAddr, ReqWData, MemDataOut
//            out: ReqReady, RespValid, RespData, RespError,
//                 MemAddress, MemDataIn, MemReadEnable, MemWriteEnable
//   master : view of the environment (requester plus data memory), the mirror
//            image of slave
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    // request handshake
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [2:0]  ReqFunct3;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    // response
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespError;
    // data memory bus
    logic [31:0] MemAddress;
    logic [31:0] MemDataIn;
    logic        MemReadEnable;
    logic        MemWriteEnable;
    logic [31:0] MemDataOut;

    modport slave (
        input  ReqValid, ReqWrite, ReqFunct3, ReqAddr, ReqWData, MemDataOut,
        output ReqReady, RespValid, RespData, RespError,
               MemAddress, MemDataIn, MemReadEnable, MemWriteEnable
    );

    modport master (
        output ReqValid, ReqWrite, ReqFunct3, ReqAddr, ReqWData, MemDataOut,
        input  ReqReady, RespValid, RespData, RespError,
               MemAddress, MemDataIn, MemReadEnable, MemWriteEnable
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Accepts one RISC-V load or store per handshake, converts the byte address
//   into a word index for a word-addressed memory without byte enables, does
//   sub-word stores as read-modify-write and returns sign/zero-extended loads.
//
//   Parameters
//     MEM_WORDS : number of 32-bit words in data memory
//   Ports
//     clk    : clock, all state changes on the rising edge
//     rst_n  : asynchronous active-low reset
//     io_bus : load_store_unit_if.slave (request, response, memory bus)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  io_bus
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;     // extracted load result or merged store word
    logic        r_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_range;
    logic        w_err;
    logic        w_is_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = (r_state == IDLE) && io_bus.ReqValid;
    assign w_is_sw  = r_write && (r_funct3 == 3'b010);

    // Request legality, evaluated on the live inputs so the verdict is
    // captured together with the request.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (io_bus.ReqWrite) begin
            w_illegal = io_bus.ReqFunct3[2] || (io_bus.ReqFunct3[1:0] == 2'b11);
        end else begin
            // 011, 111 via the low bits; 110 via the top two bits
            w_illegal = (io_bus.ReqFunct3[1:0] == 2'b11) ||
                        (io_bus.ReqFunct3[2] && io_bus.ReqFunct3[1]);
        end
        case (io_bus.ReqFunct3[1:0])
            2'b01:   w_misaligned = io_bus.ReqAddr[0];
            2'b10:   w_misaligned = (io_bus.ReqAddr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_range = ({1'b0, io_bus.ReqAddr} >= ADDR_LIMIT);
        w_err   = w_illegal || w_misaligned || w_range;
    end

    // Lane extraction, extension and store merge on the returned memory word.
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = io_bus.MemDataOut[7:0];
            2'b01:   w_byte = io_bus.MemDataOut[15:8];
            2'b10:   w_byte = io_bus.MemDataOut[23:16];
            default: w_byte = io_bus.MemDataOut[31:24];
        endcase
        w_half = r_addr[1] ? io_bus.MemDataOut[31:16] : io_bus.MemDataOut[15:0];

        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = io_bus.MemDataOut;
        endcase

        w_merged = io_bus.MemDataOut;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_bus.ReqValid) w_next = w_err ? RESP : ISSUE;
            ISSUE:   w_next = w_is_sw ? RESP : CAPTURE;
            CAPTURE: w_next = r_write ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Captured request and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= io_bus.ReqWrite;
                r_funct3 <= io_bus.ReqFunct3;
                r_addr   <= io_bus.ReqAddr;
                r_wdata  <= io_bus.ReqWData;
                r_err    <= w_err;
                r_word   <= '0;
            end
            if (r_state == CAPTURE) begin
                r_word <= r_write ? w_merged : w_load;
            end
        end
    end

    // Outputs are decoded from the state so the async reset clears strobes
    // immediately.
    always_comb begin
        io_bus.ReqReady       = (r_state == IDLE);
        io_bus.MemReadEnable  = (r_state == ISSUE) && !w_is_sw;
        io_bus.MemWriteEnable = ((r_state == ISSUE) && w_is_sw) || (r_state == WRITE);
        io_bus.MemAddress     = {2'b00, r_addr[31:2]};
        io_bus.MemDataIn      = '0;
        if ((r_state == ISSUE) && w_is_sw) begin
            io_bus.MemDataIn = r_wdata;
        end else if (r_state == WRITE) begin
            io_bus.MemDataIn = r_word;
        end
        io_bus.RespValid = (r_state == RESP);
        io_bus.RespError = (r_state == RESP) && r_err;
        io_bus.RespData  = ((r_state == RESP) && !r_write) ? r_word : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Drives load/store requests into load_store_unit, models the data memory,
//   and compares every cycle against a transaction-level reference that
//   predicts response, latency and memory strobes from the request alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int unsigned i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // ---------------- data memory model (DUT side) ----------------
    logic [31:0] mem [MEM_WORDS];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= seed_word(i);
            mem_init <= 1'b1;
            bus.MemDataOut <= '0;
        end else begin
            if (bus.MemWriteEnable) mem[bus.MemAddress % MEM_WORDS] <= bus.MemDataIn;
            if (bus.MemReadEnable)  bus.MemDataOut <= mem[bus.MemAddress % MEM_WORDS];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mem_ref [MEM_WORDS];
    bit          ref_init = 1'b0;
    bit          busy = 1'b0;
    int          n = 0;
    int          m_lat = 0, m_rd = 0, m_wr = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0, m_wdata = '0;

    task automatic predict(input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        longint unsigned size, shift, word, mask, v;
        m_addr = a; m_err = 1'b0; m_data = '0; m_wdata = '0;
        m_rd = 0; m_wr = 0;
        if (w) m_err = (f3 > 3'd2);
        else   m_err = (f3 == 3'd3) || (f3 > 3'd5);
        size = 64'd1 << f3[1:0];
        if (({32'd0, a} % size) != 0) m_err = 1'b1;
        if ({32'd0, a} >= 64'(4 * MEM_WORDS)) m_err = 1'b1;
        if (m_err) begin
            m_lat = 1;
        end else begin
            word  = {32'd0, mem_ref[a >> 2]};
            shift = 64'd8 * ({32'd0, a} % 4);
            mask  = (64'd1 << (64'd8 * size)) - 1;
            if (!w) begin
                v = (word >> shift) & mask;
                if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
                m_data = v[31:0];
                m_rd = 1; m_lat = 3;
            end else begin
                v = (word & ~(mask << shift)) | (({32'd0, d} & mask) << shift);
                m_wdata = v[31:0];
                if (size == 4) begin m_wr = 1; m_lat = 2; end
                else begin m_rd = 1; m_wr = 3; m_lat = 4; end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
            if (!ref_init) begin
                for (int unsigned i = 0; i < MEM_WORDS; i++) mem_ref[i] = seed_word(i);
                ref_init = 1'b1;
            end
        end else if (busy) begin
            if (n == m_wr) mem_ref[m_addr >> 2] = m_wdata;
            if (n == m_lat) busy = 1'b0;
            else n = n + 1;
        end else if (bus.ReqValid) begin
            predict(bus.ReqWrite, bus.ReqFunct3, bus.ReqAddr, bus.ReqWData);
            busy = 1'b1;
            n = 1;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic er, erd, ewr;
        if (!rst_n) begin
            check1 ("rst ReqReady",       bus.ReqReady,       1'b1);
            check1 ("rst RespValid",      bus.RespValid,      1'b0);
            check1 ("rst RespError",      bus.RespError,      1'b0);
            check32("rst RespData",       bus.RespData,       32'd0);
            check32("rst MemAddress",     bus.MemAddress,     32'd0);
            check32("rst MemDataIn",      bus.MemDataIn,      32'd0);
            check1 ("rst MemReadEnable",  bus.MemReadEnable,  1'b0);
            check1 ("rst MemWriteEnable", bus.MemWriteEnable, 1'b0);
        end else begin
            er  = busy && (n == m_lat);
            erd = busy && (n == m_rd);
            ewr = busy && (n == m_wr);
            check1("ReqReady",       bus.ReqReady,       !busy);
            check1("RespValid",      bus.RespValid,      er);
            check1("MemReadEnable",  bus.MemReadEnable,  erd);
            check1("MemWriteEnable", bus.MemWriteEnable, ewr);
            if (er) begin
                check1 ("RespError", bus.RespError, m_err);
                check32("RespData",  bus.RespData,  m_data);
            end
            if (erd || ewr) check32("MemAddress", bus.MemAddress, m_addr >> 2);
            if (ewr)        check32("MemDataIn",  bus.MemDataIn,  m_wdata);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        bus.ReqWrite  = 1'($urandom);
        bus.ReqFunct3 = 3'($urandom);
        bus.ReqAddr   = $urandom;
        bus.ReqWData  = $urandom;
    endtask

    // Called at a falling edge; returns at the falling edge of the response cycle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata,
                          output logic rerr, output int lat);
        bit got;
        int k;
        bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqFunct3 = f3;
        bus.ReqAddr = a; bus.ReqWData = d;
        k = 0;
        while (!bus.ReqReady && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus.ReqValid = 1'b0;
        scramble();
        lat = 0; got = 1'b0; rdata = '0; rerr = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.RespValid) begin
                got = 1'b1; rdata = bus.RespData; rerr = bus.RespError;
            end else begin
                scramble();
            end
        end
        check1("response seen", got, 1'b1);
    endtask

    task automatic req_lit(input string name, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        logic [31:0] rd; logic re; int lat;
        do_req(w, f3, a, d, rd, re, lat);
        check32({name, " data"},    rd, exp_data);
        check1 ({name, " error"},   re, exp_err);
        check32({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic stimulus();
        logic [31:0] rd, d1, d2, a;
        logic        re;
        logic [2:0]  f3;
        logic        w;
        int          lat, lat1, gap, bad;
        bit          got;
        logic [2:0]  ld_ok [5];
        ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqFunct3 = '0;
        bus.ReqAddr = '0; bus.ReqWData = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // directed sequence
        req_lit("SW 0x28",  1'b1, 3'd2, 32'h28, 32'hDEADBEEF, 32'h0,        1'b0, 2);
        check32("mem word 10 after SW", mem[10], 32'hDEADBEEF);
        req_lit("LW 0x28",  1'b0, 3'd2, 32'h28, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        req_lit("LB 0x2B",  1'b0, 3'd0, 32'h2B, 32'h0, 32'hFFFFFFDE, 1'b0, 3);
        req_lit("LBU 0x2B", 1'b0, 3'd4, 32'h2B, 32'h0, 32'h000000DE, 1'b0, 3);
        req_lit("LH 0x28",  1'b0, 3'd1, 32'h28, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
        req_lit("LHU 0x2A", 1'b0, 3'd5, 32'h2A, 32'h0, 32'h0000DEAD, 1'b0, 3);
        req_lit("SB 0x29",  1'b1, 3'd0, 32'h29, 32'h12, 32'h0,       1'b0, 4);
        req_lit("LW after SB", 1'b0, 3'd2, 32'h28, 32'h0, 32'hDEAD12EF, 1'b0, 3);
        req_lit("err LW 0x2A",  1'b0, 3'd2, 32'h2A,  32'h0, 32'h0, 1'b1, 1);
        req_lit("err SH 0x29",  1'b1, 3'd1, 32'h29,  32'h5555, 32'h0, 1'b1, 1);
        req_lit("err LW 0x400", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        req_lit("err f3 011",   1'b0, 3'd3, 32'h28,  32'h0, 32'h0, 1'b1, 1);
        req_lit("LW last word", 1'b0, 3'd2, 32'h3FC, 32'h0, seed_word(255), 1'b0, 3);

        // back-to-back with ReqValid held and inputs toggled mid-operation
        @(negedge clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqFunct3 = 3'd2;
        bus.ReqAddr = 32'h28; bus.ReqWData = '0;
        @(posedge clk); #1;
        lat1 = 0; got = 1'b0; d1 = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat1++;
            if (bus.RespValid) begin got = 1'b1; d1 = bus.RespData; end
            else begin bus.ReqAddr = $urandom; bus.ReqWData = $urandom; end
        end
        bus.ReqAddr = 32'h2C;
        gap = 0; got = 1'b0; d2 = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (bus.RespValid) begin got = 1'b1; d2 = bus.RespData; end
        end
        bus.ReqValid = 1'b0;
        check32("b2b first latency", 32'(lat1), 32'd3);
        check32("b2b first data",    d1, 32'hDEAD12EF);
        check32("b2b gap",           32'(gap), 32'd4);
        check32("b2b second data",   d2, seed_word(11));

        // reset during CAPTURE of an SH read-modify-write
        @(negedge clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = 3'd1;
        bus.ReqAddr = 32'h28; bus.ReqWData = 32'h0000CAFE;
        @(posedge clk); #1;
        bus.ReqValid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check1("mid-reset MemReadEnable",  bus.MemReadEnable,  1'b0);
        check1("mid-reset MemWriteEnable", bus.MemWriteEnable, 1'b0);
        check1("mid-reset ReqReady",       bus.ReqReady,       1'b1);
        check1("mid-reset RespValid",      bus.RespValid,      1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check32("mem word 10 after abandoned SH", mem[10], 32'hDEAD12EF);
        req_lit("LW after reset", 1'b0, 3'd2, 32'h28, 32'h0, 32'hDEAD12EF, 1'b0, 3);

        // randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 250; t++) begin
            int unsigned sel, off;
            w = 1'($urandom);
            if ($urandom % 10 == 0) f3 = 3'($urandom);
            else if (w)             f3 = 3'($urandom % 3);
            else                    f3 = ld_ok[$urandom % 5];
            sel = $urandom % 16;
            off = $urandom % 4;
            if ($urandom % 4 != 0) off = off & ~((32'd1 << f3[1:0]) - 1);
            if (sel == 0)      a = 32'(4 * MEM_WORDS) + ($urandom % 64);
            else if (sel == 1) a = $urandom;
            else if (sel == 2) a = 32'(4 * MEM_WORDS - 4) + off;
            else               a = (($urandom % 16) * 4) + off;
            do_req(w, f3, a, $urandom, rd, re, lat);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        bad = 0;
        for (int unsigned i = 0; i < MEM_WORDS; i++) if (mem[i] !== mem_ref[i]) bad++;
        check32("final memory mismatching words", 32'(bad), 32'd0);
        done = 1'b1;
    endtask

    initial begin
        fork
            stimulus();
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!done) compare_cycle();
                end
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting between the processor's memory stage and the word-addressed data memory (`DataMemory`). It accepts one RISC-V load or store per handshake and translates byte addresses into word addresses. It performs sub-word stores as read-modify-write, because the memory has no byte enables, and returns sign- or zero-extended load data. It is the initiator for the data memory's ReadEnable/WriteEnable protocol.

## Interface
- MEM_WORDS, 256, number of 32-bit words in data memory; byte addresses ≥ 4*MEM_WORDS are faults
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  unit idle, can accept a request
- ReqWrite  in  1  1 = store, 0 = load
- ReqFunct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW
- ReqAddr  in  32  byte address
- ReqWData  in  32  store data; uses low byte/half/word
- RespValid  out  1  one-cycle completion pulse
- RespData  out  32  extended load data; 0 for stores and errors
- RespError  out  1  valid with RespValid: misaligned, out of range, or illegal funct3
- MemAddress  out  32  word index {2'b00, addr[31:2]} to memory Address
- MemDataIn  out  32  word to memory DataIn
- MemReadEnable  out  1  memory read strobe
- MemWriteEnable  out  1  memory write strobe
- MemDataOut  in  32  memory DataOut; valid the cycle after a read strobe is sampled

## Operation
- States: IDLE, ISSUE, CAPTURE, WRITE, RESP.
- **IDLE:**
  - ReqReady=1.
  - On ReqValid at a clock edge, capture ReqWrite, ReqFunct3, ReqAddr and ReqWData.
  - Illegal requests go to RESP with the error flag set.
  - All other requests go to ISSUE.
- **Error conditions:**
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - addr ≥ 4*MEM_WORDS.
  - Load funct3 of 011, 110 or 111; store funct3 > 010.
- **ISSUE:**
  - SW: MemWriteEnable=1, MemDataIn=captured data. Next state RESP.
  - All other operations: MemReadEnable=1. Next state CAPTURE.
- **CAPTURE:**
  - Loads: register the extracted result. Next state RESP.
  - SB/SH: register the merged word. Next state WRITE.
- **WRITE:** MemWriteEnable=1, MemDataIn=merged word. Next state RESP.
- **RESP:** RespValid=1 for one cycle. Next state IDLE.
- **Lane selection (little-endian):**
  - Byte k=addr[1:0] is bits [8k+7:8k].
  - Half h=addr[1] is bits [16h+15:16h].
- **Extension:**
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- **Merge:** replace only the addressed byte or half of MemDataOut with the low bits of the captured store data; other lanes are unchanged.
- **Strobe rules:**
  - MemReadEnable and MemWriteEnable are never high together.
  - Each strobe is high for exactly one cycle per access.
  - MemAddress is stable from ISSUE through WRITE.
- Request inputs are ignored outside IDLE. Captured values are immune to input changes mid-operation.

## Timing
- Handshake edge = E0. Cycle n means the cycle after edge En-1.
- Error: RespValid in cycle 1; no memory strobes.
- SW: write strobe in cycle 1; RespValid in cycle 2.
- Loads: read strobe in cycle 1; data sampled in cycle 2; RespValid in cycle 3.
- SB/SH: read in cycle 1, merge in cycle 2, write in cycle 3; RespValid in cycle 4.
- ReqReady is low from cycle 1 through the RESP cycle. The next request is accepted at the edge ending the first IDLE cycle after RESP.
- The response has no backpressure.
- **Reset values (while rst_n=0):**
  - State IDLE, so ReqReady=1.
  - RespValid=0, RespError=0, RespData=0.
  - MemAddress=0, MemDataIn=0.
  - MemReadEnable=0, MemWriteEnable=0.
- **Reset mid-operation:**
  - Strobes drop immediately (asynchronously).
  - No response is issued.
  - A pending RMW write is abandoned, leaving the memory word unchanged.

## Test plan
- **SW:** reset, then SW ReqAddr=0x28, ReqWData=0xDEADBEEF.
  - Cycle 1: MemWriteEnable=1, MemAddress=10, MemDataIn=0xDEADBEEF.
  - Cycle 2: RespValid=1, RespError=0.
  - Memory word 10 = 0xDEADBEEF.
- **Loads** from that word, each with RespValid in cycle 3:
  - LW 0x28 returns 0xDEADBEEF.
  - LB 0x2B returns 0xFFFFFFDE.
  - LBU 0x2B returns 0x000000DE.
  - LH 0x28 returns 0xFFFFBEEF.
  - LHU 0x2A returns 0x0000DEAD.
- **SB** ReqAddr=0x29, ReqWData=0x12:
  - Read strobe in cycle 1, then write strobe in cycle 3 with MemDataIn=0xDEAD12EF.
  - RespValid in cycle 4.
  - A following LW 0x28 returns 0xDEAD12EF.
- **Errors:** LW 0x2A, SH 0x29, LW 0x400 (MEM_WORDS=256), and load funct3=011.
  - Each gives RespValid=1, RespError=1 in cycle 1.
  - RespData=0 and no memory strobes.
- **Reset mid-RMW:** SH 0x28 of 0xCAFE, with rst_n pulled low during CAPTURE.
  - Strobes are 0 immediately.
  - No RespValid.
  - Word 10 unchanged.
  - ReqReady=1 while and after reset.
- **Back-to-back:** ReqValid held high for two LWs, with ReqAddr/ReqWData toggled mid-operation.
  - Second request is accepted only after the first RespValid.
  - First result is unaffected by the toggled inputs.
